// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader state encoding and stream framing constants
package imem_loader_pkg;
  typedef logic [2:0] loader_state_t;
  localparam loader_state_t ST_IDLE   = 3'd0;
  localparam loader_state_t ST_LEN_LO = 3'd1;
  localparam loader_state_t ST_LEN_HI = 3'd2;
  localparam loader_state_t ST_DATA   = 3'd3;
  localparam loader_state_t ST_DONE   = 3'd4;
  localparam loader_state_t ST_ERROR  = 3'd5;
  localparam int LOADER_LEN_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles little-endian words from accepted bytes
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  localparam int CW = $clog2(WORD_BYTES);
  logic [CW-1:0] cnt_q;
  logic [31:0] shift_q;
  // Bytes enter at the top and shift down, so the first byte lands in [7:0]
  assign o_word = {i_byte, shift_q[31:8]};
  assign o_word_valid = i_accept && cnt_q == CW'(WORD_BYTES - 1);
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cnt_q <= '0;
      shift_q <= '0;
    end else begin
      cnt_q <= i_clear ? '0 : i_accept ? cnt_q + 1'b1 : cnt_q;
      shift_q <= i_accept ? o_word : shift_q;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into IMEM and holds the
// core in reset until the load completes
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 32,
  parameter int ADDR_W = $clog2(IMEM_WORDS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  output logic              o_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_reset,
  output logic              o_done,
  output logic              o_error
);
  loader_state_t state_q, state_d;
  logic ready_q, ready_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, word;
  logic [15:0] len_q, len_d, len_full;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic accept, start, word_valid;
  assign accept = i_valid && ready_q;
  assign start = i_start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign len_full = {i_data, len_q[7:0]};
  imem_loader_byte_packer u_packer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (start),
    .i_accept     (accept && state_q == ST_DATA),
    .i_byte       (i_data),
    .o_word_valid (word_valid),
    .o_word       (word)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    wcnt_d = we_q ? wcnt_q + 1'b1 : wcnt_q;
    we_d = word_valid;
    addr_d = word_valid ? wcnt_q[ADDR_W-1:0] : addr_q;
    wdata_d = word_valid ? word : wdata_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        state_d = start ? ST_LEN_LO : state_q;
        wcnt_d = start ? '0 : wcnt_d;
      end
      ST_LEN_LO: if (accept) begin
        len_d[7:0] = i_data;
        state_d = ST_LEN_HI;
      end
      ST_LEN_HI: if (accept) begin
        len_d = len_full;
        state_d = len_full == 16'd0 ? ST_DONE : len_full > 16'(IMEM_WORDS) ? ST_ERROR : ST_DATA;
      end
      ST_DATA: state_d = (!we_q && 16'(wcnt_q) == len_q) ? ST_DONE : ST_DATA;
      default: state_d = ST_IDLE;
    endcase
    // Stop accepting once the final word has been written; DONE follows next cycle
    ready_d = (state_d == ST_LEN_LO || state_d == ST_LEN_HI || state_d == ST_DATA) && !we_d &&
              !(state_d == ST_DATA && 16'(wcnt_d) == len_d);
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      len_q <= '0;
      wcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      len_q <= len_d;
      wcnt_q <= wcnt_d;
    end
  end
  assign o_ready = ready_q;
  assign o_imem_we = we_q;
  assign o_imem_addr = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_done = state_q == ST_DONE;
  assign o_error = state_q == ST_ERROR;
  assign o_core_reset = state_q != ST_DONE;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware counterpart of the bench's instruction-memory preload: accepts a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes the words sequentially into IMEM through its word write port.
- Holds the core in reset while loading and releases it when loading completes.
- Sits between the host/debug byte link and riscv_top (IMEM write port and core reset).

Parameters:
- IMEM_WORDS, 32, IMEM depth in 32-bit words.
- ADDR_W, $clog2(IMEM_WORDS), width of the IMEM word address.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begins a load session.
- i_valid  in  1  byte on i_data is valid.
- i_data  in  8  stream byte.
- o_ready  out  1  loader accepts a byte this cycle.
- o_imem_we  out  1  IMEM word write strobe.
- o_imem_addr  out  ADDR_W  IMEM word address.
- o_imem_wdata  out  32  IMEM write word.
- o_core_reset  out  1  active-high reset to riscv_top.
- o_done  out  1  load complete; core released.
- o_error  out  1  length exceeds IMEM_WORDS.

Behaviour:
- Reset: clock and reset are as already decided (one clock, i_reset synchronous active-low). While i_reset=0 at a rising edge:
  - state=IDLE; o_core_reset=1.
  - o_ready, o_imem_we, o_done, o_error = 0.
  - o_imem_addr=0; o_imem_wdata=0; byte and word counters = 0.
  - Reset mid-load abandons the session; words already written stay in IMEM.
- Handshake: a byte is accepted only when i_valid && o_ready at a rising edge. i_data is ignored otherwise.
- o_ready is registered. It is 1 only in LEN_LO, LEN_HI and DATA, except for the single cycle in which o_imem_we=1.
- Stream format:
  - 2-byte little-endian word count N, then 4*N data bytes.
  - Each word is little-endian: the first byte is bits [7:0].
- State machine:
  - IDLE: i_start -> LEN_LO.
  - LEN_LO: on accept, latch N[7:0] -> LEN_HI.
  - LEN_HI: on accept, latch N[15:8]. Then:
    - N==0 -> DONE.
    - N>IMEM_WORDS -> ERROR.
    - otherwise -> DATA.
  - DATA: shift bytes into a 32-bit assembly register; 2-bit byte counter.
    - On acceptance of the 4th byte: next cycle o_imem_we=1 for exactly one cycle, with o_imem_wdata = the assembled word and o_imem_addr = word counter. o_ready=0 in that cycle.
    - After the write, the word counter increments.
    - When the word counter reaches N -> DONE. Otherwise DATA continues.
  - DONE: o_done=1, o_core_reset=0. i_start -> LEN_LO, clears o_done and reasserts o_core_reset in the next cycle.
  - ERROR: o_error=1, o_ready=0, o_core_reset=1. Only i_start (-> LEN_LO, clears o_error) or reset exits.
- i_start is ignored in LEN_LO, LEN_HI and DATA.
- Latency: last data byte accepted at edge k -> write at edge k+1 -> o_done=1 and o_core_reset=0 from edge k+2.
- o_core_reset=1 in every state except DONE.
- Word counter width is ADDR_W+1, so N=IMEM_WORDS reaches the top address without wrapping.
- Back-pressure: i_valid low for any number of cycles stalls without loss or corruption of partial words.

Decomposition:
- riscv_defs gains:
  - loader_state_t enum {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERROR}.
  - LOADER_LEN_BYTES=2.
  - WORD_BYTES=4.
- One natural sub-module: byte_packer (byte counter + shift register; emits a word_valid pulse and a 32-bit word). The FSM stays in imem_loader.

Test Plan:
- Basic load: start; stream 02 00, 13 00 00 00, 93 00 10 00 -> IMEM[0]=32'h00000013, IMEM[1]=32'h00100093; o_done=1 and o_core_reset=0 two cycles after the last byte.
- Zero length: stream 00 00 -> DONE with no o_imem_we pulse; o_core_reset falls.
- Overflow: with IMEM_WORDS=32, stream length 21 00 -> o_error=1, o_ready=0, o_core_reset stays 1. A later i_start followed by a valid load of 1 word succeeds.
- Back-pressure: a 1-word load with i_valid toggling at random, plus i_data=FF driven while i_valid=0 -> word equals only the accepted bytes; exactly one write, to address 0.
- Full depth: 32 words of value = index -> all 32 addresses 0..31 written once in order; no wrap to address 0.
- Reset mid-load: i_reset=0 after 2 of 4 bytes of word 0 -> state IDLE, all outputs at reset values, no write issued; a subsequent full load writes correct data.
